tbird_lights_decoder: RTL and testbench

Observes the 6-bit tail-light vector driven by the turn-signal FSM and decodes it back into the signalling mode that produced it: left, right, hazard or idle. It tracks the expected frame-by-frame blink sequence, counts completed blink cycles and flags illegal patterns or transitions. It sits on the receiving end of the `lights` bus, on the same `clk` as the FSM, and serves as a mode indicator and as a self-check monitor in system tests.

---
 rtl/tbird_pkg.sv | 20 ++
 rtl/tbird_lights_decoder.sv | 86 ++++++++
 tb/tb_tbird_lights_decoder.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/tbird_pkg.sv
// tbird_pkg: shared lamp-frame constants and decoder types for the T-bird turn-signal encoder/decoder pair.
package tbird_pkg;

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT, HAZARD} mode_t;

    typedef enum logic [3:0] {
        S_OFF, S_L1, S_L2, S_L3, S_R1, S_R2, S_R3, S_H, S_SYNC
    } dec_state_t;

    // Bit order is {LC,LB,LA,RA,RB,RC}
    localparam logic [5:0] LIGHTS_OFF = 6'b000000;
    localparam logic [5:0] LIGHTS_L1  = 6'b001000;
    localparam logic [5:0] LIGHTS_L2  = 6'b011000;
    localparam logic [5:0] LIGHTS_L3  = 6'b111000;
    localparam logic [5:0] LIGHTS_R1  = 6'b000100;
    localparam logic [5:0] LIGHTS_R2  = 6'b000110;
    localparam logic [5:0] LIGHTS_R3  = 6'b000111;
    localparam logic [5:0] LIGHTS_H   = 6'b111111;

endpackage

// File: rtl/tbird_lights_decoder.sv
// tbird_lights_decoder: decodes the tail-light frame stream back into its signalling mode,
// counting completed blink cycles and flagging illegal frames or transitions.
module tbird_lights_decoder
    import tbird_pkg::*;
#(
    parameter int IDLE_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       lights,
    output logic [1:0]       mode,
    output logic             cycle_done,
    output logic [CNT_W-1:0] cycle_count,
    output logic             error
);

    localparam int IW = $clog2(IDLE_CYCLES + 1);

    dec_state_t       state_q, state_d;
    mode_t            mode_q, mode_d, done_mode;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IW-1:0]    idle_q, idle_d;
    logic             done_q, done_d, err_q, err_d, is_off;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        is_off    = lights == LIGHTS_OFF;
        done_mode = state_q == S_L3 ? LEFT : state_q == S_R3 ? RIGHT : HAZARD;
        idle_d    = !is_off ? '0 : idle_q == IW'(IDLE_CYCLES) ? idle_q : idle_q + 1'b1;
        if (state_q == S_SYNC) begin
            state_d = is_off ? S_OFF : S_SYNC;
        end else if (is_off) begin
            state_d = S_OFF;
            done_d  = state_q inside {S_L3, S_R3, S_H};
        end else begin
            case (state_q)
                S_OFF:   state_d = lights == LIGHTS_L1 ? S_L1 : lights == LIGHTS_R1 ? S_R1 : S_SYNC;
                S_L1:    state_d = lights == LIGHTS_L2 ? S_L2 : S_SYNC;
                S_L2:    state_d = lights == LIGHTS_L3 ? S_L3 : S_SYNC;
                S_R1:    state_d = lights == LIGHTS_R2 ? S_R2 : S_SYNC;
                S_R2:    state_d = lights == LIGHTS_R3 ? S_R3 : S_SYNC;
                default: state_d = S_SYNC;
            endcase
            // Hazard may interrupt any partial left/right sequence
            if (lights == LIGHTS_H && state_q != S_H) state_d = S_H;
            err_d = state_d == S_SYNC;
        end
        if (done_d) begin
            mode_d = done_mode;
            cnt_d  = done_mode != mode_q ? CNT_W'(1) : &cnt_q ? cnt_q : cnt_q + 1'b1;
        end
        if (idle_d == IW'(IDLE_CYCLES)) begin
            mode_d = IDLE;
            cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_OFF;
            mode_q  <= IDLE;
            cnt_q   <= '0;
            idle_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign mode        = mode_q;
    assign cycle_count = cnt_q;
    assign cycle_done  = done_q;
    assign error       = err_q;

endmodule

// File: tb/tb_tbird_lights_decoder.sv
// tb_tbird_lights_decoder: directed and randomized frame streams checked against a
// sequence-position reference model of the decoder.
module tb_tbird_lights_decoder;
    import tbird_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] lights = '0;
    logic [1:0] mode;
    logic       cycle_done, error;
    logic [7:0] cycle_count;

    int n_assert = 0, n_fail = 0;

    // Model: which sequence is in progress (0 none, 1 left, 2 right, 3 hazard), frames matched so far
    int         m_kind = 0, m_pos = 0, m_off = 0, m_mode = 0, m_cnt = 0;
    bit         m_sync = 0, m_done = 0, m_err = 0;
    logic [5:0] lseq [3];
    logic [5:0] rseq [3];
    logic [5:0] legal [8];

    always #5 clk = ~clk;

    tbird_lights_decoder #(.IDLE_CYCLES(2), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .lights(lights), .mode(mode),
        .cycle_done(cycle_done), .cycle_count(cycle_count), .error(error)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".mode"}, 16'(mode), 16'(m_mode));
        chk({tag, ".count"}, 16'(cycle_count), 16'(m_cnt));
        chk({tag, ".done"}, 16'(cycle_done), 16'(m_done));
        chk({tag, ".error"}, 16'(error), 16'(m_err));
    endtask

    task automatic model_reset();
        m_kind = 0; m_pos = 0; m_off = 0; m_mode = 0; m_cnt = 0;
        m_sync = 0; m_done = 0; m_err = 0;
    endtask

    task automatic model(input logic [5:0] f);
        m_done = 0;
        m_err  = 0;
        if (m_sync) begin
            if (f == 0) m_sync = 0;
        end else if (f == 0) begin
            m_done = (m_kind inside {1, 2} && m_pos == 3) || m_kind == 3;
            if (m_done) begin
                if (m_kind == m_mode) m_cnt = m_cnt < 255 ? m_cnt + 1 : 255;
                else begin m_mode = m_kind; m_cnt = 1; end
            end
            m_kind = 0; m_pos = 0;
        end else if (f == LIGHTS_H && m_kind != 3) begin
            m_kind = 3; m_pos = 1;
        end else if (m_kind != 3 && m_kind != 2 && m_pos < 3 && f == lseq[m_pos]) begin
            m_kind = 1; m_pos++;
        end else if (m_kind != 3 && m_kind != 1 && m_pos < 3 && f == rseq[m_pos]) begin
            m_kind = 2; m_pos++;
        end else begin
            m_err = 1; m_sync = 1; m_kind = 0; m_pos = 0;
        end
        m_off = f != 0 ? 0 : m_off < 2 ? m_off + 1 : 2;
        if (m_off == 2) begin m_mode = 0; m_cnt = 0; end
    endtask

    task automatic frame(input logic [5:0] f, input string tag);
        lights = f;
        @(posedge clk);
        model(f);
        #1;
        check_all(tag);
    endtask

    task automatic run_cycle(input int k, input string tag);
        if (k == 1) begin
            frame(LIGHTS_L1, tag); frame(LIGHTS_L2, tag); frame(LIGHTS_L3, tag);
        end else if (k == 2) begin
            frame(LIGHTS_R1, tag); frame(LIGHTS_R2, tag); frame(LIGHTS_R3, tag);
        end else frame(LIGHTS_H, tag);
        frame(LIGHTS_OFF, tag);
    endtask

    initial begin
        int r;
        lseq  = '{LIGHTS_L1, LIGHTS_L2, LIGHTS_L3};
        rseq  = '{LIGHTS_R1, LIGHTS_R2, LIGHTS_R3};
        legal = '{LIGHTS_OFF, LIGHTS_L1, LIGHTS_L2, LIGHTS_L3,
                  LIGHTS_R1, LIGHTS_R2, LIGHTS_R3, LIGHTS_H};
        #40;
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;

        frame(LIGHTS_OFF, "left");
        run_cycle(1, "left");
        chk("left1.count", 16'(cycle_count), 16'd1);
        run_cycle(1, "left");
        chk("left2.mode", 16'(mode), 16'd1);
        chk("left2.count", 16'(cycle_count), 16'd2);

        run_cycle(2, "right");
        run_cycle(2, "right");
        chk("right.mode", 16'(mode), 16'd2);
        chk("right.count", 16'(cycle_count), 16'd2);
        run_cycle(3, "hazard");
        chk("hazard.mode", 16'(mode), 16'd3);
        chk("hazard.count", 16'(cycle_count), 16'd1);

        run_cycle(1, "idle");
        frame(LIGHTS_OFF, "idle");
        chk("idle.mode", 16'(mode), 16'd0);
        chk("idle.count", 16'(cycle_count), 16'd0);
        frame(LIGHTS_L1, "abort");
        frame(LIGHTS_OFF, "abort");
        frame(LIGHTS_OFF, "abort");

        run_cycle(1, "illegal");
        frame(LIGHTS_L1, "illegal");
        frame(LIGHTS_R2, "illegal");
        chk("illegal.pulse", 16'(error), 16'd1);
        frame(6'b101010, "sync");
        frame(6'b101010, "sync");
        chk("sync.mode", 16'(mode), 16'd1);
        chk("sync.count", 16'(cycle_count), 16'd1);
        frame(LIGHTS_OFF, "resync");
        run_cycle(2, "resync");
        chk("resync.mode", 16'(mode), 16'd2);

        frame(LIGHTS_L1, "midreset");
        frame(LIGHTS_L2, "midreset");
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("midreset");
        @(negedge clk);
        reset = 1'b1;
        run_cycle(1, "postreset");
        chk("postreset.mode", 16'(mode), 16'd1);

        for (int i = 0; i < 260; i++) run_cycle(1, "sat");
        chk("sat.count", 16'(cycle_count), 16'd255);

        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5) run_cycle($urandom_range(1, 3), "rand.cycle");
            else if (r < 7) frame(legal[$urandom_range(0, 7)], "rand.legal");
            else if (r < 8) frame(6'($urandom), "rand.any");
            else frame(LIGHTS_OFF, "rand.off");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
